// File: rtl/crc_sender_n_if.sv
// Handshake bundle between the CRC calculator, the CRC tail sender and the
// byte coder. The master side is the sender; the slave side is the
// environment that supplies the CRC and consumes the bytes.
interface crc_sender_n_if #(
  parameter int CRC_W = 16
) ();

  // CRC calculator side
  logic [CRC_W-1:0] crc;
  logic             crc_rdy;
  logic             crc_n_rst;

  // Coder side
  logic             cd_busy;
  logic             q_rdy;
  logic [7:0]       q;

  // Transfer control and status
  logic             abort;
  logic             msg_end;
  logic             busy;
  logic             overrun;

  modport master (
    input  crc,
    input  crc_rdy,
    input  cd_busy,
    input  abort,
    output crc_n_rst,
    output q_rdy,
    output q,
    output msg_end,
    output busy,
    output overrun
  );

  modport slave (
    output crc,
    output crc_rdy,
    output cd_busy,
    output abort,
    input  crc_n_rst,
    input  q_rdy,
    input  q,
    input  msg_end,
    input  busy,
    input  overrun
  );

endinterface

// File: rtl/crc_sender_n.sv
// CRC tail sender: captures the finished CRC from the calculator, hands it
// to the byte coder one byte at a time over the q_rdy/cd_busy handshake and
// marks the end of the message with a single msg_end pulse.
// The interface instance connected to bus must carry the same CRC_W.
module crc_sender_n #(
  parameter int               CRC_W     = 16,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0
) (
  input  logic           clk,
  input  logic           n_rst,
  crc_sender_n_if.master bus
);

  localparam int NB    = CRC_W / 8;
  localparam int IDX_W = $clog2(NB + 1);

  // idx reaching this value means every byte has been taken by the coder
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t           state;
  logic [CRC_W-1:0] crc_reg;
  logic [IDX_W-1:0] idx;
  logic             crc_n_rst_r;
  logic             overrun_r;

  // Byte k of val is bits 8k+7:8k; transmission order decides which k goes
  // out for a given position in the stream. Positions past the last byte
  // are clamped so the shift stays in range even though q is masked then.
  function automatic logic [7:0] pick_byte(input logic [CRC_W-1:0] val,
                                           input logic [IDX_W-1:0] pos);
    int               sel;
    logic [CRC_W-1:0] shifted;
    if (MSB_FIRST) begin
      sel = NB - 1 - int'(pos);
    end else begin
      sel = int'(pos);
    end
    if (sel < 0) begin
      sel = 0;
    end
    shifted = val >> (8 * sel);
    return shifted[7:0];
  endfunction

  // Transfer FSM plus the registered side-band strobes to the calculator
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      crc_reg     <= '0;
      idx         <= '0;
      crc_n_rst_r <= 1'b1;
      overrun_r   <= 1'b0;
    end else begin
      // Both strobes are single-cycle: default back to inactive every cycle
      crc_n_rst_r <= 1'b1;
      overrun_r   <= 1'b0;

      if (bus.abort) begin
        // Abort wins over everything, including a CRC arriving this cycle
        state <= IDLE;
        idx   <= '0;
      end else begin
        // A CRC offered while a transfer is in flight is dropped and flagged
        if (bus.crc_rdy && (state != IDLE)) begin
          overrun_r <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (bus.crc_rdy) begin
              crc_reg     <= bus.crc ^ XOR_OUT;
              idx         <= '0;
              crc_n_rst_r <= 1'b0;
              state       <= WAIT;
            end
          end

          WAIT: begin
            // Coder must be free before the next byte (or the end mark)
            if (!bus.cd_busy) begin
              if (idx == LAST_IDX) begin
                state <= DONE;
              end else begin
                state <= SEND;
              end
            end
          end

          SEND: begin
            // cd_busy rising while the byte is offered means it was taken
            if (bus.cd_busy) begin
              idx   <= idx + IDX_W'(1);
              state <= WAIT;
            end
          end

          DONE: begin
            idx   <= '0;
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Moore outputs decoded from the registered state
  assign bus.q_rdy     = (state == SEND);
  assign bus.q         = (state == SEND) ? pick_byte(crc_reg, idx) : 8'h00;
  assign bus.msg_end   = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.crc_n_rst = crc_n_rst_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_crc_sender_n.sv
// Directed bench for crc_sender_n: a 16-bit MSB-first instance and a 32-bit
// LSB-first instance with an all-ones output XOR share clock and reset.
module tb_crc_sender_n;

  logic clk;
  logic n_rst;

  int checks;
  int errors;

  logic [7:0] pulses16;
  logic [7:0] pulses32;
  logic [7:0] exp_pulses16;

  crc_sender_n_if #(.CRC_W(16)) bus16 ();
  crc_sender_n_if #(.CRC_W(32)) bus32 ();

  crc_sender_n #(
    .CRC_W    (16),
    .MSB_FIRST(1'b1),
    .XOR_OUT  (16'h0000)
  ) u_dut16 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus16)
  );

  crc_sender_n #(
    .CRC_W    (32),
    .MSB_FIRST(1'b0),
    .XOR_OUT  (32'hFFFF_FFFF)
  ) u_dut32 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count calculator-reset pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (n_rst && !bus16.crc_n_rst) pulses16 = pulses16 + 8'd1;
    if (n_rst && !bus32.crc_n_rst) pulses32 = pulses32 + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept16(input logic [15:0] v);
    bus16.crc     = v;
    bus16.crc_rdy = 1'b1;
    step();
    chk1("acc16_crc_n_rst", bus16.crc_n_rst, 1'b0);
    chk1("acc16_busy", bus16.busy, 1'b1);
    bus16.crc_rdy = 1'b0;
    exp_pulses16  = exp_pulses16 + 8'd1;
  endtask

  task automatic run_byte16(input logic [7:0] e);
    step();
    chk1("b16_q_rdy", bus16.q_rdy, 1'b1);
    chk8("b16_q", bus16.q, e);
    bus16.cd_busy = 1'b1;
    step();
    chk1("b16_taken_q_rdy", bus16.q_rdy, 1'b0);
    chk8("b16_taken_q", bus16.q, 8'h00);
    bus16.cd_busy = 1'b0;
  endtask

  task automatic finish16();
    step();
    chk1("end16_msg_end", bus16.msg_end, 1'b1);
    chk1("end16_q_rdy", bus16.q_rdy, 1'b0);
    step();
    chk1("end16_msg_end_off", bus16.msg_end, 1'b0);
    chk1("end16_idle", bus16.busy, 1'b0);
  endtask

  task automatic run_byte32(input logic [7:0] e);
    step();
    chk1("b32_q_rdy", bus32.q_rdy, 1'b1);
    chk8("b32_q", bus32.q, e);
    bus32.cd_busy = 1'b1;
    step();
    chk1("b32_taken_q_rdy", bus32.q_rdy, 1'b0);
    bus32.cd_busy = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    pulses16      = 8'd0;
    pulses32      = 8'd0;
    exp_pulses16  = 8'd0;
    n_rst         = 1'b0;
    bus16.crc     = '0;
    bus16.crc_rdy = 1'b0;
    bus16.cd_busy = 1'b0;
    bus16.abort   = 1'b0;
    bus32.crc     = '0;
    bus32.crc_rdy = 1'b0;
    bus32.cd_busy = 1'b0;
    bus32.abort   = 1'b0;

    // Reset state
    step();
    step();
    chk1("rst_q_rdy", bus16.q_rdy, 1'b0);
    chk8("rst_q", bus16.q, 8'h00);
    chk1("rst_busy", bus16.busy, 1'b0);
    chk1("rst_crc_n_rst", bus16.crc_n_rst, 1'b1);
    chk1("rst_msg_end", bus16.msg_end, 1'b0);
    chk1("rst_overrun", bus16.overrun, 1'b0);
    chk1("rst32_busy", bus32.busy, 1'b0);
    chk8("rst32_q", bus32.q, 8'h00);
    n_rst = 1'b1;
    step();
    chk1("idle_after_rst", bus16.busy, 1'b0);

    // T1: 16'hA55A MSB first, first byte held until the coder takes it
    accept16(16'hA55A);
    step();
    chk1("t1_q_rdy", bus16.q_rdy, 1'b1);
    chk8("t1_q0", bus16.q, 8'hA5);
    chk1("t1_crc_n_rst_back", bus16.crc_n_rst, 1'b1);
    step();
    chk8("t1_q0_held", bus16.q, 8'hA5);
    bus16.cd_busy = 1'b1;
    step();
    chk1("t1_taken", bus16.q_rdy, 1'b0);
    bus16.cd_busy = 1'b0;
    run_byte16(8'h5A);
    finish16();
    chk8("t1_pulses", pulses16, exp_pulses16);

    // T2: 32-bit LSB first, XOR 0xFFFFFFFF: 12345678 -> EDCBA987
    bus32.crc     = 32'h1234_5678;
    bus32.crc_rdy = 1'b1;
    step();
    chk1("t2_crc_n_rst", bus32.crc_n_rst, 1'b0);
    bus32.crc_rdy = 1'b0;
    run_byte32(8'h87);
    run_byte32(8'hA9);
    run_byte32(8'hCB);
    run_byte32(8'hED);
    step();
    chk1("t2_msg_end", bus32.msg_end, 1'b1);
    step();
    chk1("t2_msg_end_off", bus32.msg_end, 1'b0);
    chk1("t2_idle", bus32.busy, 1'b0);
    chk8("t2_pulses", pulses32, 8'd1);

    // T3: coder busy at accept holds the sender in WAIT
    bus16.cd_busy = 1'b1;
    accept16(16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("t3_held_q_rdy", bus16.q_rdy, 1'b0);
      chk1("t3_held_busy", bus16.busy, 1'b1);
    end
    bus16.cd_busy = 1'b0;
    run_byte16(8'hBE);
    run_byte16(8'hEF);
    finish16();

    // T4: CRC strobe during the second SEND is dropped and flagged
    accept16(16'h1234);
    run_byte16(8'h12);
    step();
    chk8("t4_q1", bus16.q, 8'h34);
    bus16.crc     = 16'hFFFF;
    bus16.crc_rdy = 1'b1;
    step();
    chk1("t4_overrun", bus16.overrun, 1'b1);
    chk8("t4_q_unchanged", bus16.q, 8'h34);
    chk1("t4_no_crc_n_rst", bus16.crc_n_rst, 1'b1);
    bus16.crc_rdy = 1'b0;
    step();
    chk1("t4_overrun_off", bus16.overrun, 1'b0);
    chk8("t4_q_still", bus16.q, 8'h34);
    bus16.cd_busy = 1'b1;
    step();
    bus16.cd_busy = 1'b0;
    finish16();
    chk8("t4_pulses", pulses16, exp_pulses16);

    // T5: abort during the first SEND, abort beats crc_rdy, then a clean message
    accept16(16'hA55A);
    step();
    chk8("t5_q0", bus16.q, 8'hA5);
    bus16.abort = 1'b1;
    step();
    chk1("t5_abort_q_rdy", bus16.q_rdy, 1'b0);
    chk1("t5_abort_idle", bus16.busy, 1'b0);
    chk1("t5_abort_msg_end", bus16.msg_end, 1'b0);
    bus16.crc     = 16'hDEAD;
    bus16.crc_rdy = 1'b1;
    step();
    chk1("t5_prio_idle", bus16.busy, 1'b0);
    chk1("t5_prio_crc_n_rst", bus16.crc_n_rst, 1'b1);
    chk1("t5_prio_overrun", bus16.overrun, 1'b0);
    bus16.abort   = 1'b0;
    bus16.crc_rdy = 1'b0;
    step();
    chk1("t5_no_msg_end", bus16.msg_end, 1'b0);
    accept16(16'h0102);
    run_byte16(8'h01);
    run_byte16(8'h02);
    finish16();
    chk8("t5_pulses", pulses16, exp_pulses16);

    // T6: asynchronous reset mid-SEND, no resume afterwards
    accept16(16'hA55A);
    step();
    chk1("t6_send", bus16.q_rdy, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk1("t6_rst_q_rdy", bus16.q_rdy, 1'b0);
    chk8("t6_rst_q", bus16.q, 8'h00);
    chk1("t6_rst_busy", bus16.busy, 1'b0);
    chk1("t6_rst_crc_n_rst", bus16.crc_n_rst, 1'b1);
    chk1("t6_rst_msg_end", bus16.msg_end, 1'b0);
    step();
    step();
    n_rst = 1'b1;
    step();
    chk1("t6_idle_after", bus16.busy, 1'b0);
    chk1("t6_q_rdy_after", bus16.q_rdy, 1'b0);
    accept16(16'hC3C4);
    run_byte16(8'hC3);
    run_byte16(8'hC4);
    finish16();
    chk8("t6_pulses", pulses16, exp_pulses16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
